mult_seq_param: RTL and testbench
=================================

Name: mult_seq_param

Overview:
- Parametrised sequential multi-cycle multiplier; generalises the fixed 32x32 partial-product multiplier.
- Adds configurable operand width and partial-product chunk sizes, a per-operation signed/unsigned mode, and a one-cycle done pulse.
- The product register holds the previous result stable while the next operation runs.
- Sits beside the ALU as a shared multi-cycle multiply resource driven by a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.
A_CHUNK, 8, bits of operand a consumed per partial product; must divide WIDTH.
B_CHUNK, 16, bits of operand b consumed per partial product; must divide WIDTH.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
a  in  WIDTH  multiplicand; sampled with start.
b  in  WIDTH  multiplier; sampled with start.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse when product is updated.
product  out  2*WIDTH  result register; holds its value until the next operation completes.

Behaviour:
- Derived values:
  - NA = WIDTH/A_CHUNK.
  - NB = WIDTH/B_CHUNK.
  - N = NA*NB partial products (default 4*2 = 8).
- Reset, whenever reset=1 at an edge, including mid-operation:
  - state=IDLE, busy=0, done=0, product=0.
  - Accumulator, step counter and latched operands are cleared.
  - The reset has priority over all other events.
- FSM states: IDLE, ACCUM, FIX.
- IDLE:
  - busy=0.
  - If start=1 at an edge: latch signed_mode, then latch |a| and |b| as unsigned magnitudes (raw a, b when unsigned).
  - Also latch neg = signed_mode & (a[MSB] ^ b[MSB]), clear the accumulator and counter, and go to ACCUM.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
- ACCUM:
  - busy=1.
  - Step k runs from 0 to N-1; the a-chunk index is i = k mod NA and the b-chunk index is j = k div NA.
  - Each edge: acc += (A_chunk_i * B_chunk_j) << (i*A_CHUNK + j*B_CHUNK).
  - Each partial product is an A_CHUNK x B_CHUNK unsigned multiply; the accumulator is 2*WIDTH bits and never overflows.
  - After step N-1, go to FIX.
- FIX:
  - busy=1.
  - At the edge: product <= neg ? -acc (two's complement, 2*WIDTH bits) : acc.
  - Set done=1 for the next cycle and go to IDLE.
- Latency:
  - start sampled at edge E0; busy=1 for N+1 cycles after E0.
  - product and done become valid N+1 edges after E0, and busy=0 in that same cycle.
- Handshake rules:
  - start while busy=1 is ignored; it is neither queued nor able to corrupt the operation.
  - start in the done cycle is accepted (state is IDLE) and gives back-to-back throughput of one result per N+1 cycles.
  - done is never high together with busy.
  - a, b and signed_mode may change freely after the start edge.
- Zero operands go through the full N+1 cycles; there is no early termination.

Test Plan:
- Unsigned, default params: a=0xFFFFFFFF, b=0xFFFFFFFF, signed_mode=0 -> busy high 9 cycles; product=0xFFFFFFFE00000001 with a single-cycle done.
- Signed: a=-3 (0xFFFFFFFD), b=7, signed_mode=1 -> product=0xFFFFFFFFFFFFFFEB (-21).
- Signed corner: a=b=0x80000000, signed_mode=1 -> product=0x4000000000000000. Same operands with signed_mode=0 -> product=0x4000000000000000.
- Handshake:
  - Pulse start again mid-operation with new operands -> ignored; result matches the first operands.
  - Assert start in the done cycle with a=5, b=6 -> second done exactly 9 cycles later; product=30.
  - product holds the previous result throughout the second operation.
- Reset mid-operation: assert reset during ACCUM step 4 -> next cycle busy=0, done=0, product=0; a following start with a=2, b=3 -> product=6.
- Reparametrised WIDTH=16, A_CHUNK=4, B_CHUNK=8 (N=8): random signed and unsigned pairs -> product matches the reference model; latency is 9 cycles.

Source files
------------

// File: rtl/mult_seq_param.sv
// Sequential multiplier that accumulates A_CHUNK x B_CHUNK unsigned partial products
// of the operand magnitudes, then applies the sign in a final cycle.
module mult_seq_param #(
  parameter int WIDTH   = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int NA  = WIDTH / A_CHUNK;
  localparam int NB  = WIDTH / B_CHUNK;
  localparam int IW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW  = 2 * WIDTH;
  localparam int PPW = A_CHUNK + B_CHUNK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIX   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_mag_q, a_mag_d;
  logic [WIDTH-1:0]  b_mag_q, b_mag_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic [PW-1:0]     product_q, product_d;
  logic              done_q, done_d;

  logic [A_CHUNK-1:0] a_chunk;
  logic [B_CHUNK-1:0] b_chunk;
  logic [PPW-1:0]     pp;
  logic [PW-1:0]      pp_shifted;
  int                 shamt;
  logic               last_step;

  always_comb begin
    a_chunk    = A_CHUNK'(a_mag_q >> (int'(i_q) * A_CHUNK));
    b_chunk    = B_CHUNK'(b_mag_q >> (int'(j_q) * B_CHUNK));
    pp         = PPW'(a_chunk) * PPW'(b_chunk);
    shamt      = int'(i_q) * A_CHUNK + int'(j_q) * B_CHUNK;
    pp_shifted = PW'(pp) << shamt;
    last_step  = (i_q == IW'(NA - 1)) && (j_q == JW'(NB - 1));
  end

  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Negating the most negative value wraps back to 2^(WIDTH-1), which is
          // exactly the unsigned magnitude we want.
          a_mag_d = (signed_mode && a[WIDTH-1]) ? -a : a;
          b_mag_d = (signed_mode && b[WIDTH-1]) ? -b : b;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + pp_shifted;
        if (i_q == IW'(NA - 1)) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
        if (last_step) state_d = FIX;
      end
      FIX: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: default 32-bit instance plus a 16/4/8 instance,
// expected products queued at the start edge and checked on done.
module tb_mult_seq_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start0, sm0, busy0, done0;
  logic [31:0] a0, b0;
  logic [63:0] product0;

  logic        start1, sm1, busy1, done1;
  logic [15:0] a1, b1;
  logic [31:0] product1;

  mult_seq_param dut0 (
    .clk(clk), .reset(reset), .start(start0), .signed_mode(sm0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .product(product0)
  );

  mult_seq_param #(.WIDTH(16), .A_CHUNK(4), .B_CHUNK(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .product(product1)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] q0[$];
  logic [31:0] q1[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done0 === 1'b1) begin
      chk("done0_with_busy", 64'(busy0), 64'd0);
      if (q0.size() == 0) chk("unexpected_done0", 64'd1, 64'd0);
      else chk("product0", product0, q0.pop_front());
    end
    if (!reset && done1 === 1'b1) begin
      chk("done1_with_busy", 64'(busy1), 64'd0);
      if (q1.size() == 0) chk("unexpected_done1", 64'd1, 64'd0);
      else chk("product1", 64'(product1), 64'(q1.pop_front()));
    end
  end

  function automatic logic [63:0] model32(input logic [31:0] av, bv, input logic smv);
    logic signed [63:0] sa, sb;
    sa = smv ? {{32{av[31]}}, av} : {32'd0, av};
    sb = smv ? {{32{bv[31]}}, bv} : {32'd0, bv};
    return sa * sb;
  endfunction

  // Called between edges; the next rising edge is the start edge.
  task automatic op32(input logic [31:0] av, bv, input logic smv, input logic [63:0] expv,
                      input bit mid_start, input bit hold_chk, input logic [63:0] hold_v);
    int lat;
    int nbusy;
    a0 = av; b0 = bv; sm0 = smv; start0 = 1'b1;
    @(posedge clk);
    q0.push_back(expv);
    #1;
    start0 = 1'b0; a0 = $urandom; b0 = $urandom; sm0 = ~smv;
    nbusy = busy0 ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin lat = c; break; end
      if (busy0) nbusy++;
      if (hold_chk) chk("product_hold", product0, hold_v);
      if (mid_start) begin
        start0 = (c == 3);
        a0 = 32'h1; b0 = 32'h1;
      end
    end
    start0 = 1'b0;
    chk("latency32", 64'(lat), 64'd9);
    chk("busy_cycles32", 64'(nbusy), 64'd9);
  endtask

  task automatic op16(input logic [15:0] av, bv, input logic smv);
    int lat;
    logic signed [31:0] sa, sb;
    sa = smv ? {{16{av[15]}}, av} : {16'd0, av};
    sb = smv ? {{16{bv[15]}}, bv} : {16'd0, bv};
    a1 = av; b1 = bv; sm1 = smv; start1 = 1'b1;
    @(posedge clk);
    q1.push_back(sa * sb);
    #1;
    start1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done1) begin lat = c; break; end
    end
    chk("latency16", 64'(lat), 64'd9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
    vecs[4] = '{32'h00000000, 32'h12345678, 1'b1, 64'h0};
    vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
    vecs[8] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
    vecs[9] = '{32'h12345678, 32'h00000000, 1'b0, 64'h0};

    reset = 1'b1;
    start0 = 1'b0; sm0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_done", 64'(done0), 64'd0);
    chk("reset_product", product0, 64'd0);

    for (int k = 0; k < 10; k++) begin
      op32(vecs[k].a, vecs[k].b, vecs[k].sm, vecs[k].exp, 1'b0, 1'b0, 64'd0);
      @(posedge clk);
      #1;
      chk("done_single_cycle", 64'(done0), 64'd0);
    end

    for (int k = 0; k < 6; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      op32(ra, rb, k[0], model32(ra, rb, k[0]), 1'b0, 1'b0, 64'd0);
      @(posedge clk);
      #1;
    end

    // mid-operation start is ignored, then back-to-back start in the done cycle
    op32(32'h0000ABCD, 32'h00001234, 1'b0, 64'h000000000C374FA4, 1'b1, 1'b0, 64'd0);
    op32(32'd5, 32'd6, 1'b0, 64'd30, 1'b0, 1'b1, 64'h000000000C374FA4);
    @(posedge clk);
    #1;
    chk("after_b2b_product", product0, 64'd30);

    // reset sampled at the edge of ACCUM step 4
    a0 = 32'h00001111; b0 = 32'h00002222; sm0 = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_reset", 64'(busy0), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_busy", 64'(busy0), 64'd0);
    chk("midreset_done", 64'(done0), 64'd0);
    chk("midreset_product", product0, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("idle_after_reset", 64'(busy0), 64'd0);
    op32(32'd2, 32'd3, 1'b0, 64'd6, 1'b0, 1'b0, 64'd0);
    @(posedge clk);
    #1;

    op16(16'h8000, 16'h8000, 1'b1);
    op16(16'h8000, 16'h8000, 1'b0);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    op16(16'hFFFF, 16'h0003, 1'b1);
    for (int k = 0; k < 24; k++) begin
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), k[0]);
    end
    @(posedge clk);
    #1;

    chk("queue0_drained", 64'(q0.size()), 64'd0);
    chk("queue1_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
